// File: rtl/jam_perm_sched.sv
// Branch-and-bound cost scheduler: walks each candidate assignment over W/J, keeps min total and tie count.
// 11 cycles per full candidate (accept, NW issue, drain, compare); perm_ready only in IDLE, inputs held by sender.
module jam_perm_sched #(
    parameter int unsigned NW = 8,
    parameter int unsigned IW = 3,
    parameter int unsigned CW = 7,
    parameter int unsigned SW = 10
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NW*IW-1:0]     perm,
    input  logic                 perm_valid,
    input  logic                 perm_last,
    output logic                 perm_ready,
    output logic [IW-1:0]        W,
    output logic [IW-1:0]        J,
    input  logic [CW-1:0]        Cost,
    output logic [SW-1:0]        MinCost,
    output logic [3:0]           MatchCount,
    output logic                 Valid
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_CMP   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [IW-1:0] I_LAST  = IW'(NW - 1);
    localparam logic [3:0]    CNT_MAX = 4'd15;

    logic [2:0]       state;
    logic [IW-1:0]    i;
    logic [SW-1:0]    sum;
    logic [SW-1:0]    sum_next;
    logic [NW*IW-1:0] perm_q;
    logic             last_q;
    logic             abort;
    logic [SW-1:0]    cost_ext;

    assign cost_ext = {{(SW - CW){1'b0}}, Cost};

    // Cost lags the address by one cycle, so index i-1 lands while i is issued
    always_comb begin
        sum_next = sum;
        case (state)
            ST_ISSUE: if (i != '0) sum_next = sum + cost_ext;
            ST_DRAIN: sum_next = sum + cost_ext;
            default:  sum_next = sum;
        endcase
    end

    // Strictly greater only: a tie with the current best must still be counted
    assign abort = (((state == ST_ISSUE) && (i != '0)) || (state == ST_DRAIN))
                   && (sum_next > MinCost);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            i          <= '0;
            sum        <= '0;
            perm_q     <= '0;
            last_q     <= 1'b0;
            MinCost    <= '1;
            MatchCount <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (perm_valid) begin
                        perm_q <= perm;
                        last_q <= perm_last;
                        i      <= '0;
                        sum    <= '0;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (abort) begin
                        state <= last_q ? ST_DONE : ST_IDLE;
                    end else begin
                        sum <= sum_next;
                        i   <= i + 1'b1;
                        if (i == I_LAST) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        state <= last_q ? ST_DONE : ST_IDLE;
                    end else begin
                        sum   <= sum_next;
                        state <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (sum < MinCost) begin
                        MinCost    <= sum;
                        MatchCount <= 4'd1;
                    end else if ((sum == MinCost) && (MatchCount != CNT_MAX)) begin
                        MatchCount <= MatchCount + 4'd1;
                    end
                    state <= last_q ? ST_DONE : ST_IDLE;
                end
                ST_DONE: state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign perm_ready = (state == ST_IDLE) && !RST;
    assign W          = (state == ST_ISSUE) ? i : '0;
    assign J          = (state == ST_ISSUE) ? perm_q[i*IW +: IW] : '0;
    assign Valid      = (state == ST_DONE);

endmodule

// File: tb/tb_jam_perm_sched.sv
// Directed bench for jam_perm_sched with a one-cycle-latency cost memory model indexed by worker.
module tb_jam_perm_sched;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [23:0] perm = '0;
    logic        perm_valid = 1'b0;
    logic        perm_last = 1'b0;
    logic        perm_ready;
    logic [2:0]  W;
    logic [2:0]  J;
    logic [6:0]  Cost = '0;
    logic [9:0]  MinCost;
    logic [3:0]  MatchCount;
    logic        Valid;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] cw [8];
    logic [2:0] prev_w = '0;

    jam_perm_sched #(.NW(8), .IW(3), .CW(7), .SW(10)) dut (
        .CLK(CLK), .RST(RST), .perm(perm), .perm_valid(perm_valid),
        .perm_last(perm_last), .perm_ready(perm_ready), .W(W), .J(J),
        .Cost(Cost), .MinCost(MinCost), .MatchCount(MatchCount), .Valid(Valid)
    );

    always #5 CLK = ~CLK;

    // Cost for the address seen last cycle, changed away from the sampling edge
    always @(negedge CLK) begin
        Cost   = cw[prev_w];
        prev_w = W;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic set_cost(input int c0, input int rest);
        cw[0] = 7'(c0);
        for (int k = 1; k < 8; k++) cw[k] = 7'(rest);
    endtask

    function automatic logic [23:0] ident_perm();
        logic [23:0] p;
        for (int k = 0; k < 8; k++) p[k*3 +: 3] = 3'(k);
        return p;
    endfunction

    function automatic logic [23:0] rev_perm();
        logic [23:0] p;
        for (int k = 0; k < 8; k++) p[k*3 +: 3] = 3'(7 - k);
        return p;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        perm_valid = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    // Returns #1 after the accept edge
    task automatic send(input logic [23:0] p, input logic l);
        int n = 0;
        @(negedge CLK);
        perm = p;
        perm_last = l;
        perm_valid = 1'b1;
        while (!perm_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!perm_ready) check("accept_timeout", 0, 1);
        @(posedge CLK);
        #1;
        perm_valid = 1'b0;
    endtask

    task automatic settle();
        int n = 0;
        @(negedge CLK);
        while (!(perm_ready || Valid) && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (!(perm_ready || Valid)) check("settle_timeout", 0, 1);
    endtask

    task automatic run_cand(input logic [23:0] p, input logic l, input int c0, input int rest);
        set_cost(c0, rest);
        send(p, l);
        settle();
    endtask

    initial begin
        logic [23:0] p;
        set_cost(0, 0);

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_ready", perm_ready, 0);
        check("rst_min", MinCost, 1023);
        check("rst_cnt", MatchCount, 0);
        check("rst_valid", Valid, 0);
        check("rst_w", W, 0);
        check("rst_j", J, 0);
        RST = 1'b0;

        // Single identity candidate, every cost 5
        set_cost(5, 5);
        p = ident_perm();
        send(p, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            check($sformatf("t1_w%0d", k), W, k);
            check($sformatf("t1_j%0d", k), J, p[k*3 +: 3]);
        end
        @(negedge CLK);
        check("t1_drain_w", W, 0);
        check("t1_valid_e8", Valid, 0);
        @(negedge CLK);
        check("t1_valid_e9", Valid, 0);
        @(negedge CLK);
        check("t1_valid_e10", Valid, 1);
        check("t1_min", MinCost, 40);
        check("t1_cnt", MatchCount, 1);
        check("t1_done_ready", perm_ready, 0);

        // Totals 50, 30, 30
        do_reset();
        run_cand(rev_perm(), 1'b0, 8, 6);
        check("t2_min_a", MinCost, 50);
        set_cost(2, 4);
        send(rev_perm(), 1'b0);
        @(negedge CLK);
        check("t2_ready_issue", perm_ready, 0);
        check("t2_j0", J, 7);
        settle();
        check("t2_min_b", MinCost, 30);
        run_cand(ident_perm(), 1'b1, 2, 4);
        check("t2_min", MinCost, 30);
        check("t2_cnt", MatchCount, 2);
        check("t2_valid", Valid, 1);
        check("t2_done_ready", perm_ready, 0);

        // Early abort on first cost sample
        do_reset();
        run_cand(ident_perm(), 1'b0, 6, 2);
        check("t3_min_a", MinCost, 20);
        set_cost(25, 0);
        send(ident_perm(), 1'b0);
        @(negedge CLK);
        check("t3_w_i0", W, 0);
        @(negedge CLK);
        check("t3_w_i1", W, 1);
        @(negedge CLK);
        check("t3_w_after", W, 0);
        check("t3_ready_after", perm_ready, 1);
        check("t3_min", MinCost, 20);
        check("t3_cnt", MatchCount, 1);
        check("t3_valid", Valid, 0);
        run_cand(ident_perm(), 1'b1, 6, 2);
        check("t3_cnt_tie", MatchCount, 2);
        check("t3_valid_end", Valid, 1);

        // Count saturation
        do_reset();
        for (int c = 0; c < 17; c++) run_cand(rev_perm(), (c == 16), 2, 14);
        check("t4_min", MinCost, 100);
        check("t4_cnt", MatchCount, 15);
        check("t4_valid", Valid, 1);

        // Maximum cost, equality at the drain compare
        do_reset();
        run_cand(ident_perm(), 1'b0, 127, 127);
        check("t5_min_a", MinCost, 1016);
        check("t5_cnt_a", MatchCount, 1);
        run_cand(rev_perm(), 1'b1, 127, 127);
        check("t5_min", MinCost, 1016);
        check("t5_cnt", MatchCount, 2);
        check("t5_valid", Valid, 1);

        // Reset while issuing index 4
        do_reset();
        run_cand(ident_perm(), 1'b0, 5, 5);
        check("t6_min_a", MinCost, 40);
        send(ident_perm(), 1'b1);
        repeat (5) @(negedge CLK);
        check("t6_w_i4", W, 4);
        RST = 1'b1;
        @(negedge CLK);
        check("t6_valid", Valid, 0);
        check("t6_min", MinCost, 1023);
        check("t6_cnt", MatchCount, 0);
        check("t6_w", W, 0);
        check("t6_j", J, 0);
        check("t6_ready_rst", perm_ready, 0);
        RST = 1'b0;
        #1;
        check("t6_ready_rel", perm_ready, 1);
        run_cand(rev_perm(), 1'b1, 3, 1);
        check("t6_min_new", MinCost, 10);
        check("t6_cnt_new", MatchCount, 1);
        check("t6_valid_new", Valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jam_perm_sched.md
Name: jam_perm_sched

Overview:
- Scheduler for the job-assignment cost datapath.
- Accepts one candidate assignment at a time from the permutation generator over a valid/ready handshake.
- For each candidate it walks the NW worker/job pairs on the W/J address bus, accumulates the returned Cost, and abandons the candidate early once its partial sum exceeds the best total so far.
- Tracks the minimum total cost and how many assignments reach it; raises Valid after the generator's last candidate is retired.

Parameters:
- NW, 8, number of workers = jobs per assignment
- IW, 3, worker/job index width (clog2 NW)
- CW, 7, width of one Cost sample
- SW, 10, accumulator/MinCost width (NW*(2^CW-1) = 1016 fits)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- perm  in  NW*IW  candidate assignment; job for worker k at bits [k*IW +: IW]
- perm_valid  in  1  candidate present
- perm_last  in  1  candidate is the final one; qualified by perm_valid
- perm_ready  out  1  scheduler can accept a candidate
- W  out  IW  worker index presented to cost memory
- J  out  IW  job index presented to cost memory
- Cost  in  CW  cost for the W/J pair presented in the previous cycle
- MinCost  out  SW  minimum total found
- MatchCount  out  4  number of assignments with total == MinCost, saturating
- Valid  out  1  results final

Behaviour:
- Reset (RST=1 at a clock edge):
  - state=IDLE, i=0, sum=0.
  - MinCost=10'h3FF, MatchCount=0, Valid=0.
  - W=0, J=0.
  - perm_ready=0 while RST is high.
  - Reset mid-operation discards the in-flight candidate and all results.
- States: IDLE, ISSUE, DRAIN, CMP, DONE.
- IDLE:
  - perm_ready=1.
  - On perm_valid&perm_ready: latch perm into perm_q, perm_last into last_q; i=0, sum=0 -> ISSUE.
- ISSUE:
  - W=i, J=perm_q[i].
  - If i>=1, Cost belongs to index i-1: sum_next=sum+Cost, otherwise sum_next=sum.
  - i increments each cycle; after i=NW-1 -> DRAIN.
- DRAIN:
  - W=J=0.
  - sum_next=sum+Cost (cost of index NW-1) -> CMP.
- Early abort, in ISSUE with i>=1 and in DRAIN:
  - Condition: sum_next > MinCost.
  - Action: drop the candidate, no result update; go to DONE if last_q, else IDLE.
  - Equality never aborts.
- CMP:
  - If sum<MinCost: MinCost=sum, MatchCount=1.
  - Else if sum==MinCost: MatchCount=min(MatchCount+1, 15).
  - Then DONE if last_q, else IDLE.
- DONE:
  - Valid=1 held; MinCost/MatchCount frozen.
  - perm_ready=0; W=J=0.
  - Leaves only on RST.
- Outside ISSUE, W and J are 0. Both are decoded from the registered state and i, so they are glitch-free at the clock edge.
- Latency, non-aborted candidate: accept edge + 8 ISSUE + 1 DRAIN + 1 CMP = 11 cycles per candidate. Valid is high the cycle after the last CMP.
- The first candidate never aborts: MinCost=1023 exceeds the maximum sum of 1016.
- perm, perm_valid and perm_last are ignored in every state except IDLE. The generator must hold them until accepted.
- Arithmetic is unsigned; the SW-bit sum cannot overflow.

Test Plan:
- Single candidate, identity perm, every Cost=5, perm_last=1:
  - W/J sequence (0,0)..(7,7).
  - MinCost=40, MatchCount=1.
  - Valid rises 11 cycles after the accept edge.
- Three candidates with totals 50, 30, 30, last on the third:
  - MinCost=30, MatchCount=2, Valid=1.
  - perm_ready low except in IDLE.
- Early abort:
  - Candidate 1 totals 20.
  - Candidate 2 returns Cost=25 for W=0.
  - Abort on the ISSUE cycle with i=1; W never reaches 2; back to IDLE next cycle; MinCost=20, MatchCount=1 unchanged.
- Saturation: 17 candidates each totaling 100 -> MinCost=100, MatchCount=15.
- Boundary: all Cost=127 -> MinCost=1016, no wrap. A second candidate totaling 1016 (equal) -> MatchCount=2, no abort.
- RST asserted during ISSUE i=4:
  - Next edge: Valid=0, MinCost=1023, MatchCount=0, W=J=0.
  - perm_ready=1 on the first cycle after RST drops.
  - A fresh candidate is processed correctly.
